unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the pipelined CPU's IF-stage fetch port and MEM-stage data port.
//  Sequences fixed-latency memory accesses; data port has priority, bounded by an instruction-starvation guard.
//  Sits between the CPU's i_*/d_* interfaces and the memory; i_ack/d_ack low = requester must stall.
//  Counts arbitration conflicts for performance reporting.
// PARAMETERS
//  WORD_SIZE    16  data/address width
//  MEM_LATENCY  2   cycles m_req is held per access (>=1)
//  STARVE_LIMIT 3   consecutive lost arbitrations by fetch before fetch is forced to win (>=1)
//  CNT_WIDTH    16  width of conflict_cnt
// PORTS
//  Clk          in   1          clock, all state updates on posedge
//  Reset_N      in   1          synchronous active-low reset
//  i_req        in   1          fetch read request, held until i_ack
//  i_addr       in   WORD_SIZE  fetch address
//  i_rdata      out  WORD_SIZE  fetched word, valid when i_ack=1
//  i_ack        out  1          one-cycle completion pulse for fetch
//  d_req        in   1          data request, held until d_ack
//  d_we         in   1          1=write, 0=read
//  d_addr       in   WORD_SIZE  data address
//  d_wdata      in   WORD_SIZE  write data
//  d_rdata      out  WORD_SIZE  read data, valid when d_ack=1 after a read
//  d_ack        out  1          one-cycle completion pulse for data
//  m_req        out  1          memory access active
//  m_we         out  1          memory write enable (only while m_req=1)
//  m_addr       out  WORD_SIZE  memory address
//  m_wdata      out  WORD_SIZE  memory write data
//  m_rdata      in   WORD_SIZE  memory read data, valid on last ACCESS cycle
//  conflict_cnt out  CNT_WIDTH  saturating count of arbitrations with both requests asserted
// BEHAVIOUR
//  Reset (Reset_N=0 at any posedge, incl. mid-access): state=IDLE; all outputs 0; latency counter, starvation
//    counter, latched request regs cleared; an in-flight access is abandoned with no ack.
//  States: IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE: arbitrate on sampled reqs. None: stay. Only one: grant it. Both: grant data unless
//    starve_cnt==STARVE_LIMIT, then grant fetch. On grant, latch owner/we/addr/wdata (fetch: we=0),
//    load lat_cnt=MEM_LATENCY-1, go ACCESS.
//  starve_cnt: +1 when both requested and data won; cleared when fetch is granted; unchanged otherwise.
//  conflict_cnt: +1 on each IDLE arbitration with i_req&d_req; saturates at all-ones.
//  ACCESS: m_req=1; m_we/m_addr/m_wdata from latched regs (stable throughout). lat_cnt decrements each cycle;
//    at lat_cnt==0, next posedge captures m_rdata into owner's rdata reg (reads only) and goes DONE.
//  DONE: owner's ack=1 for exactly this cycle, m_req=0; reqs are NOT sampled; next state IDLE.
//  Latency: req sampled in IDLE at edge N -> ACCESS cycles N+1..N+MEM_LATENCY -> ack in cycle N+MEM_LATENCY+1.
//    Minimum request-to-request spacing for one port is MEM_LATENCY+2 cycles.
//  Writes: d_rdata keeps its previous value; d_ack still pulses.
//  Requester dropping req mid-access: access still completes and ack pulses once; no retry.
//  i_rdata/d_rdata hold last captured value between accesses. m_addr/m_wdata hold last value when m_req=0.
//  Never both acks in one cycle; never more than one access in flight.
// TESTING (MEM_LATENCY=2, STARVE_LIMIT=3 unless noted)
//  1. Lone fetch i_addr=0x0010, mem returns 0xA5A5 -> m_req=1 two cycles, m_we=0; i_ack in 3rd cycle after
//     sampling, i_rdata=0xA5A5; d_ack stays 0; conflict_cnt=0.
//  2. i_req + d_req(write 0x0020<=0x1234) same cycle -> data first (m_we=1, m_addr=0x0020, m_wdata=0x1234),
//     d_ack; then fetch granted next IDLE; conflict_cnt=1.
//  3. d_req and i_req held continuously -> grants D,D,D,I,D,D,D,I...; starve_cnt resets after each I grant.
//  4. Reset_N=0 for 1 cycle during 2nd ACCESS cycle of a data read -> no d_ack; all outputs 0; next request served
//     normally with full latency.
//  5. d_req read dropped after 1 cycle of ACCESS -> exactly one d_ack, d_rdata=m_rdata; no second access.
//  6. CNT_WIDTH=2, 5 contended arbitrations -> conflict_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the unified memory.
// The slave view belongs to the arbiter; the master view to the CPU plus memory side.
interface unified_mem_arbiter_if #(
    parameter int WORD_SIZE = 16
);
    logic                 i_req;
    logic [WORD_SIZE-1:0] i_addr;
    logic [WORD_SIZE-1:0] i_rdata;
    logic                 i_ack;

    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic [WORD_SIZE-1:0] d_rdata;
    logic                 d_ack;

    logic                 m_req;
    logic                 m_we;
    logic [WORD_SIZE-1:0] m_addr;
    logic [WORD_SIZE-1:0] m_wdata;
    logic [WORD_SIZE-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between the CPU fetch and data ports with a
// fixed-latency access sequence, data priority and a fetch starvation guard.
//
// state  | meaning
// IDLE   | sample requests, arbitrate, latch the winner's access
// ACCESS | m_req held for MEM_LATENCY cycles, read data captured on the last one
// DONE   | one-cycle ack to the owner, requests not sampled
module unified_mem_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    unified_mem_arbiter_if.slave bus,
    output logic [CNT_WIDTH-1:0] conflict_cnt
);

    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LAT_W-1:0]       r_lat_cnt;
    logic [STV_W-1:0]       r_starve_cnt;
    logic                   r_owner_d;
    logic                   r_we;
    logic [WORD_SIZE-1:0]   r_addr;
    logic [WORD_SIZE-1:0]   r_wdata;
    logic [WORD_SIZE-1:0]   r_i_rdata;
    logic [WORD_SIZE-1:0]   r_d_rdata;
    logic [CNT_WIDTH-1:0]   r_conflict_cnt;

    logic w_both;
    logic w_starve_full;
    logic w_grant;
    logic w_grant_d;

    assign w_both        = bus.i_req & bus.d_req;
    assign w_starve_full = (r_starve_cnt == STV_W'(STARVE_LIMIT));

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_req | bus.d_req) begin
                    w_grant     = 1'b1;
                    // Data wins unless fetch has already lost STARVE_LIMIT contended rounds in a row.
                    w_grant_d   = bus.d_req & ~(w_both & w_starve_full);
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (r_lat_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            r_lat_cnt      <= '0;
            r_starve_cnt   <= '0;
            r_owner_d      <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_i_rdata      <= '0;
            r_d_rdata      <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                if (w_both && (r_conflict_cnt != '1)) begin
                    r_conflict_cnt <= r_conflict_cnt + CNT_WIDTH'(1);
                end
                if (w_grant) begin
                    r_owner_d <= w_grant_d;
                    r_we      <= w_grant_d & bus.d_we;
                    r_addr    <= w_grant_d ? bus.d_addr : bus.i_addr;
                    r_lat_cnt <= LAT_W'(MEM_LATENCY - 1);
                    if (w_grant_d) begin
                        r_wdata <= bus.d_wdata;
                    end
                    if (!w_grant_d) begin
                        r_starve_cnt <= '0;
                    end else if (w_both) begin
                        r_starve_cnt <= r_starve_cnt + STV_W'(1);
                    end
                end
            end else if (r_state == ST_ACCESS) begin
                if (r_lat_cnt == '0) begin
                    if (!r_we) begin
                        if (r_owner_d) begin
                            r_d_rdata <= bus.m_rdata;
                        end else begin
                            r_i_rdata <= bus.m_rdata;
                        end
                    end
                end else begin
                    r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                end
            end
        end
    end

    assign bus.m_req     = (r_state == ST_ACCESS);
    assign bus.m_we      = (r_state == ST_ACCESS) & r_we;
    assign bus.m_addr    = r_addr;
    assign bus.m_wdata   = r_wdata;
    assign bus.i_ack     = (r_state == ST_DONE) & ~r_owner_d;
    assign bus.d_ack     = (r_state == ST_DONE) & r_owner_d;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign conflict_cnt  = r_conflict_cnt;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios plus a randomized
// run against a transaction-timeline reference model; a CNT_WIDTH=2 copy checks saturation.
module tb_unified_mem_arbiter;

    localparam int W  = 16;
    localparam int L  = 2;
    localparam int SL = 3;

    logic        Clk     = 1'b0;
    logic        Reset_N = 1'b0;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;
    int          n_cmp = 0;
    int          n_bad = 0;

    unified_mem_arbiter_if #(.WORD_SIZE(W)) bus ();
    unified_mem_arbiter_if #(.WORD_SIZE(W)) bus2 ();

    unified_mem_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(L), .STARVE_LIMIT(SL), .CNT_WIDTH(16)) dut (
        .Clk(Clk), .Reset_N(Reset_N), .bus(bus), .conflict_cnt(cnt1)
    );
    unified_mem_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(L), .STARVE_LIMIT(SL), .CNT_WIDTH(2)) dut2 (
        .Clk(Clk), .Reset_N(Reset_N), .bus(bus2), .conflict_cnt(cnt2)
    );

    assign bus2.i_req   = bus.i_req;
    assign bus2.i_addr  = bus.i_addr;
    assign bus2.d_req   = bus.d_req;
    assign bus2.d_we    = bus.d_we;
    assign bus2.d_addr  = bus.d_addr;
    assign bus2.d_wdata = bus.d_wdata;
    assign bus2.m_rdata = bus.m_rdata;

    always #5 Clk = ~Clk;

    typedef struct {
        bit          ack;
        bit          last;
        bit          port_d;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } slot_t;

    task automatic nxt();
        @(negedge Clk);
    endtask

    task automatic idle_in();
        bus.i_req   = 1'b0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.i_addr  = '0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    task automatic do_reset();
        idle_in();
        Reset_N = 1'b0;
        nxt();
        nxt();
        Reset_N = 1'b1;
    endtask

    task automatic test_reset();
        Reset_N     = 1'b0;
        bus.i_req   = 1'b1;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.i_addr  = 16'(($urandom));
        bus.d_addr  = 16'(($urandom));
        bus.d_wdata = 16'(($urandom));
        bus.m_rdata = 16'(($urandom));
        nxt();
        nxt();
        n_cmp++;
        if ({bus.m_req, bus.m_we, bus.i_ack, bus.d_ack} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b want 0000", {bus.m_req, bus.m_we, bus.i_ack, bus.d_ack});
        end
        n_cmp++;
        if ({bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 0", {bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata});
        end
        n_cmp++;
        if (cnt1 !== 16'h0 || cnt2 !== 2'h0) begin
            n_bad++;
            $display("FAIL reset_cnt: got %h/%h want 0/0", cnt1, cnt2);
        end
        idle_in();
        Reset_N = 1'b1;
        nxt();
        n_cmp++;
        if ({bus.m_req, bus.i_ack, bus.d_ack} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_release: got %b want 000", {bus.m_req, bus.i_ack, bus.d_ack});
        end
    endtask

    task automatic test_lone_fetch();
        bus.i_req   = 1'b1;
        bus.i_addr  = 16'h0010;
        bus.m_rdata = 16'hA5A5;
        for (int c = 1; c <= 2; c++) begin
            nxt();
            n_cmp++;
            if ({bus.m_req, bus.m_we, bus.i_ack, bus.d_ack} !== 4'b1000 || bus.m_addr !== 16'h0010) begin
                n_bad++;
                $display("FAIL fetch_access%0d: ctl=%b addr=%h want ctl=1000 addr=0010", c,
                         {bus.m_req, bus.m_we, bus.i_ack, bus.d_ack}, bus.m_addr);
            end
        end
        nxt();
        n_cmp++;
        if ({bus.m_req, bus.m_we, bus.i_ack, bus.d_ack} !== 4'b0010 || bus.i_rdata !== 16'hA5A5) begin
            n_bad++;
            $display("FAIL fetch_ack: ctl=%b rdata=%h want ctl=0010 rdata=a5a5",
                     {bus.m_req, bus.m_we, bus.i_ack, bus.d_ack}, bus.i_rdata);
        end
        bus.i_req = 1'b0;
        nxt();
        n_cmp++;
        if ({bus.m_req, bus.i_ack, bus.d_ack} !== 3'b000 || cnt1 !== 16'h0) begin
            n_bad++;
            $display("FAIL fetch_after: ctl=%b cnt=%h want ctl=000 cnt=0", {bus.m_req, bus.i_ack, bus.d_ack}, cnt1);
        end
    endtask

    task automatic test_contention();
        logic [3:0]  exp_ctl  [7];
        logic [15:0] exp_addr [7];
        exp_ctl  = '{4'b1100, 4'b1100, 4'b0001, 4'b0000, 4'b1000, 4'b1000, 4'b0010};
        exp_addr = '{16'h0020, 16'h0020, 16'h0020, 16'h0020, 16'h0040, 16'h0040, 16'h0040};
        bus.i_req   = 1'b1;
        bus.i_addr  = 16'h0040;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 16'h0020;
        bus.d_wdata = 16'h1234;
        bus.m_rdata = 16'h5A5A;
        for (int c = 0; c < 7; c++) begin
            nxt();
            n_cmp++;
            if ({bus.m_req, bus.m_we, bus.i_ack, bus.d_ack} !== exp_ctl[c] || bus.m_addr !== exp_addr[c]) begin
                n_bad++;
                $display("FAIL contention_cyc%0d: ctl=%b addr=%h want ctl=%b addr=%h", c + 1,
                         {bus.m_req, bus.m_we, bus.i_ack, bus.d_ack}, bus.m_addr, exp_ctl[c], exp_addr[c]);
            end
            if (c == 0) begin
                n_cmp++;
                if (bus.m_wdata !== 16'h1234) begin
                    n_bad++;
                    $display("FAIL contention_wdata: got %h want 1234", bus.m_wdata);
                end
            end
            if (c == 2) bus.d_req = 1'b0;
        end
        n_cmp++;
        if (bus.i_rdata !== 16'h5A5A || bus.d_rdata !== 16'h0000) begin
            n_bad++;
            $display("FAIL contention_rdata: i=%h d=%h want i=5a5a d=0000", bus.i_rdata, bus.d_rdata);
        end
        n_cmp++;
        if (cnt1 !== 16'd1 || cnt2 !== 2'd1) begin
            n_bad++;
            $display("FAIL contention_cnt: got %0d/%0d want 1/1", cnt1, cnt2);
        end
        bus.i_req = 1'b0;
        nxt();
    endtask

    task automatic test_reset_mid_access();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 16'h0050;
        bus.m_rdata = 16'h7777;
        nxt();
        nxt();
        n_cmp++;
        if (bus.m_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_access: m_req=%b want 1", bus.m_req);
        end
        Reset_N   = 1'b0;
        bus.d_req = 1'b0;
        nxt();
        n_cmp++;
        if ({bus.m_req, bus.m_we, bus.i_ack, bus.d_ack} !== 4'b0000 ||
            {bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata} !== 64'h0 || cnt1 !== 16'h0) begin
            n_bad++;
            $display("FAIL rstmid_clear: ctl=%b data=%h cnt=%h want all 0",
                     {bus.m_req, bus.m_we, bus.i_ack, bus.d_ack},
                     {bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata}, cnt1);
        end
        Reset_N = 1'b1;
        nxt();
        n_cmp++;
        if ({bus.m_req, bus.i_ack, bus.d_ack} !== 3'b000) begin
            n_bad++;
            $display("FAIL rstmid_noack: ctl=%b want 000", {bus.m_req, bus.i_ack, bus.d_ack});
        end
        bus.d_req   = 1'b1;
        bus.d_addr  = 16'h0060;
        bus.m_rdata = 16'hBEEF;
        for (int c = 1; c <= 2; c++) begin
            nxt();
            n_cmp++;
            if ({bus.m_req, bus.d_ack} !== 2'b10 || bus.m_addr !== 16'h0060) begin
                n_bad++;
                $display("FAIL rstmid_retry_acc%0d: ctl=%b addr=%h want ctl=10 addr=0060", c,
                         {bus.m_req, bus.d_ack}, bus.m_addr);
            end
        end
        nxt();
        n_cmp++;
        if ({bus.m_req, bus.d_ack} !== 2'b01 || bus.d_rdata !== 16'hBEEF) begin
            n_bad++;
            $display("FAIL rstmid_retry_ack: ctl=%b rdata=%h want ctl=01 rdata=beef",
                     {bus.m_req, bus.d_ack}, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        nxt();
    endtask

    task automatic test_starvation();
        int g;
        int sat;
        do_reset();
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h0008;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 16'h0030;
        for (int cyc = 1; cyc <= 32; cyc++) begin
            bus.m_rdata = 16'(cyc);
            nxt();
            if (cyc % 4 == 3) begin
                g   = cyc / 4;
                sat = (g + 1 > 3) ? 3 : g + 1;
                n_cmp++;
                if ({bus.i_ack, bus.d_ack} !== ((g % 4 == 3) ? 2'b10 : 2'b01)) begin
                    n_bad++;
                    $display("FAIL starve_grant%0d: acks(i,d)=%b want %s", g, {bus.i_ack, bus.d_ack},
                             (g % 4 == 3) ? "fetch" : "data");
                end
                n_cmp++;
                if (cnt1 !== 16'(g + 1) || cnt2 !== 2'(sat)) begin
                    n_bad++;
                    $display("FAIL starve_cnt%0d: got %0d/%0d want %0d/%0d", g, cnt1, cnt2, g + 1, sat);
                end
            end else begin
                n_cmp++;
                if ({bus.i_ack, bus.d_ack} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL starve_noack_cyc%0d: acks=%b want 00", cyc, {bus.i_ack, bus.d_ack});
                end
            end
            if (cyc == 32) idle_in();
        end
        nxt();
    endtask

    task automatic test_drop_req();
        int          acks;
        int          extra;
        logic [15:0] rd;
        acks  = 0;
        extra = 0;
        rd    = '0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 16'h0070;
        bus.m_rdata = 16'h1357;
        nxt();
        bus.d_req = 1'b0;
        for (int c = 0; c < 8; c++) begin
            nxt();
            if (bus.d_ack === 1'b1) begin
                acks++;
                rd = bus.d_rdata;
            end
            if (c >= 2 && bus.m_req === 1'b1) extra++;
        end
        n_cmp++;
        if (acks !== 1 || extra !== 0) begin
            n_bad++;
            $display("FAIL drop_req_once: acks=%0d extra_access_cycles=%0d want 1/0", acks, extra);
        end
        n_cmp++;
        if (rd !== 16'h1357) begin
            n_bad++;
            $display("FAIL drop_req_rdata: got %h want 1357", rd);
        end
    endtask

    task automatic test_random();
        slot_t       q[$];
        slot_t       s;
        slot_t       ns;
        bit          idle, exp_mreq, ia, da, both, win_d;
        bit          i_pend, d_pend, d_we_r;
        logic [15:0] i_addr_r, d_addr_r, d_wdata_r;
        logic [15:0] last_addr, exp_i_rd, exp_d_rd;
        int          conflicts, starve, sat;
        i_pend = 0; d_pend = 0; d_we_r = 0;
        i_addr_r = '0; d_addr_r = '0; d_wdata_r = '0;
        last_addr = '0; exp_i_rd = '0; exp_d_rd = '0;
        conflicts = 0; starve = 0;
        do_reset();
        for (int cyc = 0; cyc < 900; cyc++) begin
            idle = (q.size() == 0);
            s    = '{default: '0};
            if (!idle) s = q.pop_front();
            exp_mreq = !idle && !s.ack;
            ia       = !idle && s.ack && !s.port_d;
            da       = !idle && s.ack && s.port_d;
            if (exp_mreq) last_addr = s.addr;
            sat = (conflicts > 3) ? 3 : conflicts;

            n_cmp++;
            if ({bus.m_req, bus.m_we, bus.i_ack, bus.d_ack} !== {exp_mreq, exp_mreq && s.we, ia, da}) begin
                n_bad++;
                $display("FAIL rand_ctl cyc%0d: got %b want %b", cyc,
                         {bus.m_req, bus.m_we, bus.i_ack, bus.d_ack}, {exp_mreq, exp_mreq && s.we, ia, da});
            end
            n_cmp++;
            if (bus.m_addr !== last_addr) begin
                n_bad++;
                $display("FAIL rand_addr cyc%0d: got %h want %h", cyc, bus.m_addr, last_addr);
            end
            if (exp_mreq && s.we) begin
                n_cmp++;
                if (bus.m_wdata !== s.wdata) begin
                    n_bad++;
                    $display("FAIL rand_wdata cyc%0d: got %h want %h", cyc, bus.m_wdata, s.wdata);
                end
            end
            n_cmp++;
            if (bus.i_rdata !== exp_i_rd || bus.d_rdata !== exp_d_rd) begin
                n_bad++;
                $display("FAIL rand_rdata cyc%0d: got i=%h d=%h want i=%h d=%h", cyc,
                         bus.i_rdata, bus.d_rdata, exp_i_rd, exp_d_rd);
            end
            n_cmp++;
            if (cnt1 !== 16'(conflicts) || cnt2 !== 2'(sat)) begin
                n_bad++;
                $display("FAIL rand_cnt cyc%0d: got %0d/%0d want %0d/%0d", cyc, cnt1, cnt2, conflicts, sat);
            end

            if (ia) i_pend = 0;
            if (da) d_pend = 0;
            if (!i_pend && $urandom_range(2) == 0) begin
                i_pend   = 1;
                i_addr_r = 16'($urandom);
            end
            if (!d_pend && $urandom_range(2) == 0) begin
                d_pend    = 1;
                d_we_r    = 1'($urandom_range(1));
                d_addr_r  = 16'($urandom);
                d_wdata_r = 16'($urandom);
            end
            bus.i_req   = i_pend;
            bus.i_addr  = i_addr_r;
            bus.d_req   = d_pend;
            bus.d_we    = d_we_r;
            bus.d_addr  = d_addr_r;
            bus.d_wdata = d_wdata_r;
            bus.m_rdata = 16'($urandom);

            if (!idle && s.last && !s.we) begin
                if (s.port_d) exp_d_rd = bus.m_rdata;
                else          exp_i_rd = bus.m_rdata;
            end
            if (idle && (i_pend || d_pend)) begin
                both  = i_pend && d_pend;
                win_d = d_pend && !(both && starve == SL);
                if (both) conflicts++;
                if (!win_d) starve = 0;
                else if (both) starve++;
                for (int j = 0; j <= L; j++) begin
                    ns.ack    = (j == L);
                    ns.last   = (j == L - 1);
                    ns.port_d = win_d;
                    ns.we     = win_d && d_we_r;
                    ns.addr   = win_d ? d_addr_r : i_addr_r;
                    ns.wdata  = d_wdata_r;
                    q.push_back(ns);
                end
            end
            nxt();
        end
    endtask

    initial begin
        idle_in();
        bus.m_rdata = '0;
        test_reset();
        test_lone_fetch();
        test_contention();
        test_reset_mid_access();
        test_starvation();
        test_drop_req();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
